// File: rtl/cfu_dispatcher.sv
// CFU dispatcher: shares one core CFU port among NUM_CFU units, returns responses
// in issue order via an ordering FIFO, and answers requests to absent units locally.
module cfu_dispatcher #(
    parameter int NUM_CFU         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_cfu_csr,
    input  logic [8:0]                         req_id,
    input  logic [7:0]                         req_cfu,
    input  logic [7:0]                         req_state,
    input  logic [9:0]                         req_func,
    input  logic [31:0]                        req_insn,
    input  logic [31:0]                        req_data0,
    input  logic [31:0]                        req_data1,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [8:0]                         resp_id,
    output logic [2:0]                         resp_status,
    output logic [31:0]                        resp_data,
    output logic [NUM_CFU-1:0]                 u_req_valid,
    input  logic [NUM_CFU-1:0]                 u_req_ready,
    output logic                               u_req_cfu_csr,
    output logic [8:0]                         u_req_id,
    output logic [7:0]                         u_req_state,
    output logic [9:0]                         u_req_func,
    output logic [31:0]                        u_req_insn,
    output logic [31:0]                        u_req_data0,
    output logic [31:0]                        u_req_data1,
    input  logic [NUM_CFU-1:0]                 u_resp_valid,
    output logic [NUM_CFU-1:0]                 u_resp_ready,
    input  logic [9*NUM_CFU-1:0]               u_resp_id,
    input  logic [3*NUM_CFU-1:0]               u_resp_status,
    input  logic [32*NUM_CFU-1:0]              u_resp_data,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               id_mismatch
);

    localparam int IW = (NUM_CFU > 1) ? $clog2(NUM_CFU) : 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int OW = PW + 1;
    localparam logic [7:0]    NUM_CFU_B = 8'(NUM_CFU);
    localparam logic [OW-1:0] DEPTH     = OW'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] fifo_err;
    logic [IW-1:0]              fifo_unit [MAX_OUTSTANDING];
    logic [8:0]                 fifo_id   [MAX_OUTSTANDING];
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [OW-1:0]              count;
    logic                       mismatch;

    logic          hit;
    logic [IW-1:0] idx;
    logic          full;
    logic          sel_ready;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic          head_err;
    logic [IW-1:0] head_unit;
    logic [8:0]    head_id;
    logic          unit_valid;
    logic [8:0]    unit_id;
    logic [2:0]    unit_status;
    logic [31:0]   unit_data;

    assign u_req_cfu_csr = req_cfu_csr;
    assign u_req_id      = req_id;
    assign u_req_state   = req_state;
    assign u_req_func    = req_func;
    assign u_req_insn    = req_insn;
    assign u_req_data0   = req_data0;
    assign u_req_data1   = req_data1;
    assign outstanding   = count;
    assign id_mismatch   = mismatch;

    // Request decode and forwarding; absent units are always ready so the error entry can queue.
    always_comb begin
        hit         = (req_cfu < NUM_CFU_B);
        idx         = req_cfu[IW-1:0];
        full        = (count == DEPTH);
        sel_ready   = 1'b0;
        u_req_valid = '0;
        for (int k = 0; k < NUM_CFU; k++) begin
            u_req_valid[k] = (idx == IW'(k)) & req_valid & hit & ~full & rst_n;
            sel_ready      = sel_ready | ((idx == IW'(k)) & u_req_ready[k]);
        end
        req_ready = rst_n & ~full & (hit ? sel_ready : 1'b1);
        push      = req_valid & req_ready;
    end

    // Select the response fields of the unit owning the FIFO head.
    always_comb begin
        head_valid  = rst_n & (count != {OW{1'b0}});
        head_err    = fifo_err[rd_ptr];
        head_unit   = fifo_unit[rd_ptr];
        head_id     = fifo_id[rd_ptr];
        unit_valid  = 1'b0;
        unit_id     = 9'd0;
        unit_status = 3'd0;
        unit_data   = 32'd0;
        for (int k = 0; k < NUM_CFU; k++) begin
            if (head_unit == IW'(k)) begin
                unit_valid  = u_resp_valid[k];
                unit_id     = u_resp_id[9*k +: 9];
                unit_status = u_resp_status[3*k +: 3];
                unit_data   = u_resp_data[32*k +: 32];
            end else begin
                unit_valid  = unit_valid;
            end
        end
    end

    // Response steering to the core; only the head unit may hand over its response.
    always_comb begin
        resp_valid   = 1'b0;
        resp_id      = 9'd0;
        resp_status  = 3'd0;
        resp_data    = 32'd0;
        u_resp_ready = '0;
        if (!head_valid) begin
            resp_valid = 1'b0;
        end else if (head_err) begin
            resp_valid  = 1'b1;
            resp_id     = head_id;
            resp_status = 3'b001;
            resp_data   = 32'd0;
        end else begin
            resp_valid  = unit_valid;
            resp_id     = unit_id;
            resp_status = unit_status;
            resp_data   = unit_data;
            for (int k = 0; k < NUM_CFU; k++) begin
                u_resp_ready[k] = (head_unit == IW'(k)) & resp_ready;
            end
        end
        pop = resp_valid & resp_ready;
    end

    // Ordering FIFO storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_err <= '0;
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                fifo_unit[k] <= '0;
                fifo_id[k]   <= 9'd0;
            end
        end else if (push) begin
            fifo_err[wr_ptr]  <= ~hit;
            fifo_unit[wr_ptr] <= idx;
            fifo_id[wr_ptr]   <= req_id;
        end else begin
            fifo_err <= fifo_err;
        end
    end

    // Pointers, occupancy and the sticky ID-mismatch flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mismatch <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
            if (pop && !head_err && (unit_id != head_id)) begin
                mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cfu_dispatcher.sv
// Directed testbench for cfu_dispatcher (NUM_CFU=2, MAX_OUTSTANDING=4): per-cycle vector
// table plus hand-written full/wrap, streaming and reset sequences.
module tb_cfu_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_cfu_csr;
    logic [8:0]  req_id;
    logic [7:0]  req_cfu;
    logic [7:0]  req_state;
    logic [9:0]  req_func;
    logic [31:0] req_insn;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic        resp_valid;
    logic        resp_ready;
    logic [8:0]  resp_id;
    logic [2:0]  resp_status;
    logic [31:0] resp_data;
    logic [1:0]  u_req_valid;
    logic [1:0]  u_req_ready;
    logic        u_req_cfu_csr;
    logic [8:0]  u_req_id;
    logic [7:0]  u_req_state;
    logic [9:0]  u_req_func;
    logic [31:0] u_req_insn;
    logic [31:0] u_req_data0;
    logic [31:0] u_req_data1;
    logic [1:0]  u_resp_valid;
    logic [1:0]  u_resp_ready;
    logic [17:0] u_resp_id;
    logic [5:0]  u_resp_status;
    logic [63:0] u_resp_data;
    logic [2:0]  outstanding;
    logic        id_mismatch;

    int passed = 0;
    int total  = 0;

    cfu_dispatcher #(.NUM_CFU(2), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cfu_csr(req_cfu_csr),
        .req_id(req_id), .req_cfu(req_cfu), .req_state(req_state), .req_func(req_func),
        .req_insn(req_insn), .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_status(resp_status), .resp_data(resp_data),
        .u_req_valid(u_req_valid), .u_req_ready(u_req_ready), .u_req_cfu_csr(u_req_cfu_csr),
        .u_req_id(u_req_id), .u_req_state(u_req_state), .u_req_func(u_req_func),
        .u_req_insn(u_req_insn), .u_req_data0(u_req_data0), .u_req_data1(u_req_data1),
        .u_resp_valid(u_resp_valid), .u_resp_ready(u_resp_ready), .u_resp_id(u_resp_id),
        .u_resp_status(u_resp_status), .u_resp_data(u_resp_data),
        .outstanding(outstanding), .id_mismatch(id_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [7:0]  cfu;
        logic [8:0]  id;
        logic [1:0]  urdy;
        logic [1:0]  uvld;
        logic [8:0]  uid0;
        logic [8:0]  uid1;
        logic [2:0]  ust0;
        logic [2:0]  ust1;
        logic [31:0] udat0;
        logic [31:0] udat1;
        logic        rrdy;
        logic        e_rrdy;
        logic [1:0]  e_uv;
        logic        e_rv;
        logic [8:0]  e_rid;
        logic [2:0]  e_rst;
        logic [31:0] e_rdat;
        logic [1:0]  e_urr;
        logic [2:0]  e_out;
        logic        e_mm;
    } vec_t;

    vec_t vec [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        req_valid     = v.rv;
        req_cfu       = v.cfu;
        req_id        = v.id;
        u_req_ready   = v.urdy;
        u_resp_valid  = v.uvld;
        u_resp_id     = {v.uid1, v.uid0};
        u_resp_status = {v.ust1, v.ust0};
        u_resp_data   = {v.udat1, v.udat0};
        resp_ready    = v.rrdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] qid [$];
    logic       qunit [$];

    initial begin
        // Table: rv cfu id urdy uvld uid0 uid1 ust0 ust1 udat0 udat1 rrdy | rrdy uv rv rid rst rdat urr out mm
        vec[0]  = '{1'b1, 8'd1, 9'h005, 2'b11, 2'b00, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b1, 2'b10, 1'b0, 9'h000, 3'd0, 32'h0, 2'b00, 3'd0, 1'b0};
        vec[1]  = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b10, 9'h000, 9'h005, 3'd0, 3'd0, 32'h0, 32'hDEADBEEF, 1'b1,
                    1'b1, 2'b00, 1'b1, 9'h005, 3'd0, 32'hDEADBEEF, 2'b10, 3'd1, 1'b0};
        vec[2]  = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b00, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b1, 2'b00, 1'b0, 9'h000, 3'd0, 32'h0, 2'b00, 3'd0, 1'b0};
        vec[3]  = '{1'b1, 8'd0, 9'h001, 2'b11, 2'b00, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b1, 2'b01, 1'b0, 9'h000, 3'd0, 32'h0, 2'b00, 3'd0, 1'b0};
        vec[4]  = '{1'b1, 8'd1, 9'h002, 2'b11, 2'b00, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b1, 2'b10, 1'b0, 9'h000, 3'd0, 32'h0, 2'b01, 3'd1, 1'b0};
        vec[5]  = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b10, 9'h000, 9'h002, 3'd0, 3'd0, 32'h0, 32'h22, 1'b1,
                    1'b1, 2'b00, 1'b0, 9'h000, 3'd0, 32'h0, 2'b01, 3'd2, 1'b0};
        vec[6]  = vec[5];
        vec[7]  = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b11, 9'h001, 9'h002, 3'd0, 3'd0, 32'h11, 32'h22, 1'b1,
                    1'b1, 2'b00, 1'b1, 9'h001, 3'd0, 32'h11, 2'b01, 3'd2, 1'b0};
        vec[8]  = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b10, 9'h000, 9'h002, 3'd0, 3'd0, 32'h0, 32'h22, 1'b1,
                    1'b1, 2'b00, 1'b1, 9'h002, 3'd0, 32'h22, 2'b10, 3'd1, 1'b0};
        vec[9]  = vec[2];
        vec[10] = '{1'b1, 8'd7, 9'h01A, 2'b00, 2'b00, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b1, 2'b00, 1'b0, 9'h000, 3'd0, 32'h0, 2'b00, 3'd0, 1'b0};
        vec[11] = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b11, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0,
                    1'b1, 2'b00, 1'b1, 9'h01A, 3'b001, 32'h0, 2'b00, 3'd1, 1'b0};
        vec[12] = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b11, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b1, 2'b00, 1'b1, 9'h01A, 3'b001, 32'h0, 2'b00, 3'd1, 1'b0};
        vec[13] = '{1'b1, 8'd0, 9'h009, 2'b10, 2'b00, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b0, 2'b01, 1'b0, 9'h000, 3'd0, 32'h0, 2'b00, 3'd0, 1'b0};
        vec[14] = '{1'b1, 8'd0, 9'h004, 2'b11, 2'b00, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b1, 2'b01, 1'b0, 9'h000, 3'd0, 32'h0, 2'b00, 3'd0, 1'b0};
        vec[15] = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b01, 9'h003, 9'h000, 3'b010, 3'd0, 32'h33, 32'h0, 1'b1,
                    1'b1, 2'b00, 1'b1, 9'h003, 3'b010, 32'h33, 2'b01, 3'd1, 1'b0};
        vec[16] = '{1'b0, 8'd0, 9'h000, 2'b11, 2'b00, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1,
                    1'b1, 2'b00, 1'b0, 9'h000, 3'd0, 32'h0, 2'b00, 3'd0, 1'b1};

        rst_n = 1'b0;
        req_cfu_csr = 1'b0; req_state = 8'h5A; req_func = 10'h155;
        req_insn = 32'h0000_000B; req_data0 = 32'h1111_2222; req_data1 = 32'h3333_4444;
        apply(vec[2]);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("reset outstanding", 32'(outstanding), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset id_mismatch", 32'(id_mismatch), 32'd0);
        check("reset u_resp_ready", 32'(u_resp_ready), 32'd0);
        check("broadcast data0", u_req_data0, 32'h1111_2222);
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            apply(vec[i]);
            @(negedge clk);
            check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vec[i].e_rrdy));
            check($sformatf("row%0d u_req_valid", i), 32'(u_req_valid), 32'(vec[i].e_uv));
            check($sformatf("row%0d resp_valid", i), 32'(resp_valid), 32'(vec[i].e_rv));
            check($sformatf("row%0d resp_id", i), 32'(resp_id), 32'(vec[i].e_rid));
            check($sformatf("row%0d resp_status", i), 32'(resp_status), 32'(vec[i].e_rst));
            check($sformatf("row%0d resp_data", i), resp_data, vec[i].e_rdat);
            check($sformatf("row%0d u_resp_ready", i), 32'(u_resp_ready), 32'(vec[i].e_urr));
            check($sformatf("row%0d outstanding", i), 32'(outstanding), 32'(vec[i].e_out));
            check($sformatf("row%0d id_mismatch", i), 32'(id_mismatch), 32'(vec[i].e_mm));
            next_cycle();
        end

        // Fill to full, hold a fifth request across a pop, then drain in order.
        apply(vec[2]);
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            req_id    = 9'(9'h040 + k);
            @(negedge clk);
            check($sformatf("fill%0d req_ready", k), 32'(req_ready), 32'd1);
            next_cycle();
        end
        req_valid = 1'b1;
        req_id    = 9'h044;
        @(negedge clk);
        check("full outstanding", 32'(outstanding), 32'd4);
        check("full req_ready", 32'(req_ready), 32'd0);
        check("full u_req_valid", 32'(u_req_valid), 32'd0);
        next_cycle();
        u_resp_valid = 2'b01;
        u_resp_id    = {9'h000, 9'h040};
        @(negedge clk);
        check("pop-when-full resp_id", 32'(resp_id), 32'h040);
        check("pop-when-full req_ready", 32'(req_ready), 32'd0);
        next_cycle();
        u_resp_valid = 2'b00;
        @(negedge clk);
        check("after-pop outstanding", 32'(outstanding), 32'd3);
        check("after-pop req_ready", 32'(req_ready), 32'd1);
        check("after-pop u_req_valid", 32'(u_req_valid), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            u_resp_valid = 2'b01;
            u_resp_id    = {9'h000, 9'(9'h040 + k)};
            @(negedge clk);
            check($sformatf("drain%0d resp_valid", k), 32'(resp_valid), 32'd1);
            check($sformatf("drain%0d resp_id", k), 32'(resp_id), 32'(9'h040 + k));
            check($sformatf("drain%0d outstanding", k), 32'(outstanding), 32'(5 - k));
            next_cycle();
        end
        u_resp_valid = 2'b00;
        @(negedge clk);
        check("drained outstanding", 32'(outstanding), 32'd0);
        next_cycle();

        // Back-to-back streaming: one request and one response per cycle.
        for (int i = 0; i < 12; i++) begin
            req_valid    = (i < 10);
            req_cfu      = 8'(i % 2);
            req_id       = 9'(9'h080 + i);
            u_req_ready  = 2'b11;
            resp_ready   = 1'b1;
            u_resp_valid = 2'b00;
            if (qid.size() > 0) begin
                if (qunit[0] == 1'b0) begin
                    u_resp_valid = 2'b01;
                    u_resp_id    = {9'h000, qid[0]};
                    u_resp_data  = {32'h0, 23'd0, qid[0]};
                end else begin
                    u_resp_valid = 2'b10;
                    u_resp_id    = {qid[0], 9'h000};
                    u_resp_data  = {23'd0, qid[0], 32'h0};
                end
            end
            @(negedge clk);
            check($sformatf("stream%0d outstanding", i), 32'(outstanding), 32'(qid.size()));
            if (i < 10) begin
                check($sformatf("stream%0d req_ready", i), 32'(req_ready), 32'd1);
            end
            if (qid.size() > 0) begin
                check($sformatf("stream%0d resp_valid", i), 32'(resp_valid), 32'd1);
                check($sformatf("stream%0d resp_id", i), 32'(resp_id), 32'(qid[0]));
                check($sformatf("stream%0d resp_data", i), resp_data, 32'(qid[0]));
            end
            next_cycle();
            if (qid.size() > 0) begin
                void'(qid.pop_front());
                void'(qunit.pop_front());
            end
            if (i < 10) begin
                qid.push_back(9'(9'h080 + i));
                qunit.push_back(i % 2 == 1);
            end
        end

        // Reset with two entries outstanding and the mismatch flag set.
        apply(vec[2]);
        req_valid = 1'b1; req_cfu = 8'd1; req_id = 9'h010;
        next_cycle();
        req_id = 9'h011;
        @(negedge clk);
        check("prereset outstanding1", 32'(outstanding), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("prereset outstanding2", 32'(outstanding), 32'd2);
        check("prereset id_mismatch", 32'(id_mismatch), 32'd1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("postreset outstanding", 32'(outstanding), 32'd0);
        check("postreset id_mismatch", 32'(id_mismatch), 32'd0);
        check("postreset resp_valid", 32'(resp_valid), 32'd0);
        check("postreset u_resp_ready", 32'(u_resp_ready), 32'd0);
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
